// File: rtl/exec_cc_mreg_if.sv
// Signal bundle between the execute stage and its condition-code / E->M register back end.
// The pipeline control side drives E-stage values and M-register control; the back end returns flags and M fields.
interface exec_cc_mreg_if #(
    parameter int W = 64
);
    logic [3:0]   e_icode;
    logic [3:0]   e_ifun;
    logic [W-1:0] e_alu_out;
    logic         e_alu_of;
    logic [W-1:0] e_valA;
    logic [3:0]   e_dstE;
    logic [3:0]   e_dstM;
    logic [1:0]   e_stat;
    logic         m_exc;
    logic         w_exc;
    logic         m_stall;
    logic         m_bubble;

    logic         cc_zf;
    logic         cc_sf;
    logic         cc_of;
    logic         e_cnd;
    logic [3:0]   e_dstE_eff;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;
    logic [1:0]   M_stat;

    modport master (
        output e_icode, e_ifun, e_alu_out, e_alu_of, e_valA, e_dstE, e_dstM, e_stat,
        output m_exc, w_exc, m_stall, m_bubble,
        input  cc_zf, cc_sf, cc_of, e_cnd, e_dstE_eff,
        input  M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, M_stat
    );

    modport slave (
        input  e_icode, e_ifun, e_alu_out, e_alu_of, e_valA, e_dstE, e_dstM, e_stat,
        input  m_exc, w_exc, m_stall, m_bubble,
        output cc_zf, cc_sf, cc_of, e_cnd, e_dstE_eff,
        output M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, M_stat
    );
endinterface

// File: rtl/exec_cc_mreg.sv
// Y86-64 execute back end: ZF/SF/OF register, jXX/cmovXX condition evaluation,
// cmov destination squash and the E->M pipeline register with stall/bubble.
module exec_cc_mreg #(
    parameter int         W          = 64,
    parameter logic [3:0] ICODE_OPQ  = 4'h6,
    parameter logic [3:0] ICODE_CMOV = 4'h2,
    parameter logic [3:0] ICODE_NOP  = 4'h1,
    parameter logic [3:0] RNONE      = 4'hF
) (
    input logic           clk,
    input logic           reset,
    exec_cc_mreg_if.slave bus
);
    logic         zf_q;
    logic         sf_q;
    logic         of_q;
    logic         set_cc;
    logic         cnd;
    logic [3:0]   dst_e_eff;

    logic [3:0]   m_icode_q;
    logic         m_cnd_q;
    logic [W-1:0] m_val_e_q;
    logic [W-1:0] m_val_a_q;
    logic [3:0]   m_dst_e_q;
    logic [3:0]   m_dst_m_q;
    logic [1:0]   m_stat_q;

    // Flags freeze as soon as an older instruction has raised an exception.
    assign set_cc = (bus.e_icode == ICODE_OPQ) & ~bus.m_exc & ~bus.w_exc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (set_cc) begin
            zf_q <= (bus.e_alu_out == '0);
            sf_q <= bus.e_alu_out[W-1];
            of_q <= bus.e_alu_of;
        end
    end

    // Condition uses the registered flags only; an OPq is seen by the next instruction.
    always_comb begin
        cnd = 1'b0;
        case (bus.e_ifun)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = (sf_q ^ of_q) | zf_q;
            4'h2:    cnd = sf_q ^ of_q;
            4'h3:    cnd = zf_q;
            4'h4:    cnd = ~zf_q;
            4'h5:    cnd = ~(sf_q ^ of_q);
            4'h6:    cnd = ~(sf_q ^ of_q) & ~zf_q;
            default: cnd = 1'b0;
        endcase
    end

    always_comb begin
        dst_e_eff = bus.e_dstE;
        if ((bus.e_icode == ICODE_CMOV) && !cnd) begin
            dst_e_eff = RNONE;
        end
    end

    // Bubble wins over stall; asserting both together is a control-logic error upstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_icode_q <= ICODE_NOP;
            m_cnd_q   <= 1'b0;
            m_val_e_q <= '0;
            m_val_a_q <= '0;
            m_dst_e_q <= RNONE;
            m_dst_m_q <= RNONE;
            m_stat_q  <= 2'd0;
        end else if (bus.m_bubble) begin
            m_icode_q <= ICODE_NOP;
            m_cnd_q   <= 1'b0;
            m_val_e_q <= '0;
            m_val_a_q <= '0;
            m_dst_e_q <= RNONE;
            m_dst_m_q <= RNONE;
            m_stat_q  <= 2'd0;
        end else if (!bus.m_stall) begin
            m_icode_q <= bus.e_icode;
            m_cnd_q   <= cnd;
            m_val_e_q <= bus.e_alu_out;
            m_val_a_q <= bus.e_valA;
            m_dst_e_q <= dst_e_eff;
            m_dst_m_q <= bus.e_dstM;
            m_stat_q  <= bus.e_stat;
        end
    end

    assign bus.cc_zf      = zf_q;
    assign bus.cc_sf      = sf_q;
    assign bus.cc_of      = of_q;
    assign bus.e_cnd      = cnd;
    assign bus.e_dstE_eff = dst_e_eff;
    assign bus.M_icode    = m_icode_q;
    assign bus.M_cnd      = m_cnd_q;
    assign bus.M_valE     = m_val_e_q;
    assign bus.M_valA     = m_val_a_q;
    assign bus.M_dstE     = m_dst_e_q;
    assign bus.M_dstM     = m_dst_m_q;
    assign bus.M_stat     = m_stat_q;
endmodule

// File: doc/exec_cc_mreg.md
Name: exec_cc_mreg

Overview:
- Execute-stage back end of the Y86-64 pipeline, directly downstream of the 64-bit ALU.
- Holds the condition-code register (ZF/SF/OF), updated from ALU results.
- Evaluates the jXX/cmovXX condition against the current flags and squashes the destination of untaken conditional moves.
- Contains the E->M pipeline register with stall and bubble control, feeding the memory stage.

Parameters:
- W, 64, data width of valE/valA.
- ICODE_OPQ, 4'h6, icode whose execution updates the condition codes.
- ICODE_CMOV, 4'h2, icode of rrmovq/cmovXX.
- ICODE_NOP, 4'h1, icode inserted on a bubble.
- RNONE, 4'hF, "no register" id.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- e_icode  in  4  icode of the instruction in E
- e_ifun  in  4  ifun (ALU op or condition code)
- e_alu_out  in  W  ALU result (valE)
- e_alu_of  in  1  ALU carry_overflow output, used as OF
- e_valA  in  W  valA passed through E
- e_dstE  in  4  decoded dstE
- e_dstM  in  4  decoded dstM
- e_stat  in  2  status (0 AOK, 1 HLT, 2 ADR, 3 INS)
- m_exc  in  1  memory stage holds or produces a non-AOK status
- w_exc  in  1  writeback stage holds a non-AOK status
- m_stall  in  1  hold the M register
- m_bubble  in  1  load a NOP into the M register
- cc_zf, cc_sf, cc_of  out  1 each  current flags
- e_cnd  out  1  condition result (combinational)
- e_dstE_eff  out  4  effective dstE, used for forwarding (combinational)
- M_icode  out  4  registered icode
- M_cnd  out  1  registered condition
- M_valE  out  W  registered valE
- M_valA  out  W  registered valA
- M_dstE  out  4  registered dstE
- M_dstM  out  4  registered dstM
- M_stat  out  2  registered status

Behaviour:
- Reset (asynchronous; takes effect immediately and holds while high):
  - Flags: cc_zf=1, cc_sf=0, cc_of=0.
  - M register loads the bubble image: M_icode=ICODE_NOP, M_cnd=0, M_valE=0, M_valA=0, M_dstE=RNONE, M_dstM=RNONE, M_stat=0.
- CC update:
  - set_cc = (e_icode==ICODE_OPQ) & ~m_exc & ~w_exc.
  - On a posedge with set_cc: ZF<=(e_alu_out==0), SF<=e_alu_out[W-1], OF<=e_alu_of. Otherwise the flags hold.
  - CC update is independent of m_stall/m_bubble.
- Condition, combinational from the current (pre-edge) flags:
  - ifun 0: 1
  - ifun 1 (le): (SF^OF)|ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): ~ZF
  - ifun 5 (ge): ~(SF^OF)
  - ifun 6 (g): ~(SF^OF)&~ZF
  - ifun 7..15: 0
  - e_cnd is computed for every icode.
- Effective dstE: e_dstE_eff = RNONE when e_icode==ICODE_CMOV & ~e_cnd; otherwise e_dstE.
- Flag latency:
  - An OPq in E changes the flags at the end of its cycle.
  - The following instruction (jXX/cmov) in E sees the new flags.
  - No same-cycle bypass.
- M register, on each posedge with reset low, in priority order:
  - m_bubble: load the bubble image.
  - m_stall: hold all fields.
  - Otherwise: load {e_icode, e_cnd, e_alu_out, e_valA, e_dstE_eff, e_dstM, e_stat}.
  - m_bubble & m_stall together is illegal; the bench asserts it never occurs, and RTL behaviour is bubble.
- Exceptions:
  - Once m_exc or w_exc is high, the flags are frozen.
  - The non-AOK e_stat itself still propagates into M_stat.
- Reset asserted mid-operation clears the flags and the M register asynchronously, with no edge required. The first post-reset edge behaves normally.

Test Plan:
- Reset: assert reset mid-cycle -> flags=1/0/0 and M_icode=1, M_dstE=F, M_stat=0 immediately, before any clock edge.
- OPq then branch: OPq with e_alu_out=0, of=0 -> ZF=1, SF=0, OF=0 after the edge. Next cycle jXX ifun=3 -> e_cnd=1; ifun=4 -> e_cnd=0.
- Signed compare: OPq with e_alu_out=64'h8000_0000_0000_0000, of=1 -> SF=1, OF=1. Then ifun 2 -> 0, ifun 5 -> 1, ifun 6 -> 1, ifun 1 -> 0.
- Untaken cmov: ZF=0, e_icode=2, ifun=3, e_dstE=4'h3 -> e_dstE_eff=F and M_dstE=F, M_cnd=0. With ifun=0 -> M_dstE=3.
- Exception freeze: flags 1/0/0, OPq with e_alu_out=5 and m_exc=1 -> flags unchanged. Same op with w_exc=1 -> unchanged. Both 0 -> ZF=0.
- Stall/bubble: load valE=64'h1234; then m_stall=1 with new inputs -> M_valE stays 64'h1234. Then m_bubble=1 -> M_icode=1, M_valE=0, M_dstE=F, M_dstM=F.
